dso100fb_timing: RTL and testbench

Display timing generator for the DSO100 framebuffer controller. It sits directly downstream of the APB register block: it consumes the START/STOP strobes, the twelve segment lengths and three polarity bits, and returns STARTED/STOPPED pulses and STATE. It drives the panel HSYNC/VSYNC/DE pins and emits frame/line/overlay qualifiers to the pixel fetch and overlay mixer stages.

---
 rtl/dso100fb_timing_pkg.sv | 34 +++
 rtl/dso100fb_timing_axis.sv | 58 +++++
 rtl/dso100fb_timing.sv | 145 ++++++++++++++
 tb/tb_dso100fb_timing.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dso100fb_timing_pkg.sv
// Shared types and constants for the DSO100 framebuffer display timing generator.
package dso100fb_timing_pkg;

  typedef logic [11:0] len_t;
  typedef len_t [5:0]  seg_lens_t;
  typedef logic [2:0]  seg_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STOPPING = 2'b10
  } state_t;

  localparam seg_idx_t SEG_BEFORE     = 3'd0;
  localparam seg_idx_t SEG_OVERLAY    = 3'd1;
  localparam seg_idx_t SEG_AFTER      = 3'd2;
  localparam seg_idx_t SEG_FRONTPORCH = 3'd3;
  localparam seg_idx_t SEG_SYNC       = 3'd4;
  localparam seg_idx_t SEG_BACKPORCH  = 3'd5;
  localparam seg_idx_t SEG_NONE       = 3'd6;

  // Lowest segment index >= from with a nonzero length, SEG_NONE if there is none.
  function automatic seg_idx_t next_nonzero(input seg_lens_t lens, input seg_idx_t from);
    seg_idx_t r;
    seg_idx_t j;
    r = SEG_NONE;
    for (int unsigned i = 6; i > 0; i--) begin
      j = seg_idx_t'(i - 1);
      if (j >= from && lens[j] != '0) r = j;
    end
    return r;
  endfunction

endpackage

// File: rtl/dso100fb_timing_axis.sv
// One timing axis: shadowed segment lengths, segment index and in-segment counter with zero-length skip.
module dso100fb_timing_axis
  import dso100fb_timing_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      LOAD,
  input  logic      ADVANCE,
  input  seg_lens_t LEN_IN,
  output seg_idx_t  SEG,
  output logic      AT_FIRST,
  output logic      LAST
);

  seg_lens_t shadow_q;
  seg_idx_t  seg_q;
  len_t      cnt_q;

  len_t     cur_len;
  logic     seg_end;
  seg_idx_t nxt_seg;
  seg_idx_t first_seg;
  seg_idx_t load_seg;

  always_comb begin
    cur_len   = (seg_q <= SEG_BACKPORCH) ? shadow_q[seg_q] : '0;
    seg_end   = (cur_len == '0) || (cnt_q == cur_len - len_t'(1));
    nxt_seg   = next_nonzero(shadow_q, seg_q + seg_idx_t'(1));
    first_seg = next_nonzero(shadow_q, SEG_BEFORE);
    if (first_seg == SEG_NONE) first_seg = SEG_BEFORE;
    load_seg  = next_nonzero(LEN_IN, SEG_BEFORE);
    if (load_seg == SEG_NONE) load_seg = SEG_BEFORE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
      seg_q    <= SEG_BEFORE;
      cnt_q    <= '0;
    end else if (LOAD) begin
      shadow_q <= LEN_IN;
      seg_q    <= load_seg;
      cnt_q    <= '0;
    end else if (ADVANCE) begin
      if (seg_end) begin
        seg_q <= (nxt_seg == SEG_NONE) ? first_seg : nxt_seg;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + len_t'(1);
      end
    end
  end

  assign SEG      = seg_q;
  assign AT_FIRST = (cnt_q == '0) && (seg_q == first_seg);
  assign LAST     = seg_end && (nxt_seg == SEG_NONE);

endmodule

// File: rtl/dso100fb_timing.sv
// DSO100 framebuffer display timing generator: start/stop FSM, H/V axes, registered panel pins.
// Define DSO100FB_TIMING_OVERLAY_EN to drive OVERLAY; otherwise it is tied low.
module dso100fb_timing
  import dso100fb_timing_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  output logic        STARTED,
  output logic        STOPPED,
  output logic [1:0]  STATE,
  input  logic [11:0] TIMING_WIDTHBEFOREOVERLAY,
  input  logic [11:0] TIMING_WIDTHOVERLAY,
  input  logic [11:0] TIMING_WIDTHAFTEROVERLAY,
  input  logic [11:0] TIMING_HFRONTPORCH,
  input  logic [11:0] TIMING_HSYNCPULSE,
  input  logic [11:0] TIMING_HBACKPORCH,
  input  logic [11:0] TIMING_HEIGHTBEFOREOVERLAY,
  input  logic [11:0] TIMING_HEIGHTOVERLAY,
  input  logic [11:0] TIMING_HEIGHTAFTEROVERLAY,
  input  logic [11:0] TIMING_VFRONTPORCH,
  input  logic [11:0] TIMING_VSYNCPULSE,
  input  logic [11:0] TIMING_VBACKPORCH,
  input  logic        HSYNC_POLARITY,
  input  logic        VSYNC_POLARITY,
  input  logic        DE_POLARITY,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic        OVERLAY,
  output logic        LINE_START,
  output logic        FRAME_START
);

  state_t    state_q, state_d;
  seg_lens_t h_lens, v_lens;
  seg_idx_t  h_seg, v_seg;
  logic      h_first, v_first, h_last, v_last;
  logic      running, frame_end, start_acc, load;
  logic      started_d, stopped_d;
  logic      de_act, hs_act, vs_act, ovl_act;

  assign h_lens = {TIMING_HBACKPORCH, TIMING_HSYNCPULSE, TIMING_HFRONTPORCH,
                   TIMING_WIDTHAFTEROVERLAY, TIMING_WIDTHOVERLAY, TIMING_WIDTHBEFOREOVERLAY};
  assign v_lens = {TIMING_VBACKPORCH, TIMING_VSYNCPULSE, TIMING_VFRONTPORCH,
                   TIMING_HEIGHTAFTEROVERLAY, TIMING_HEIGHTOVERLAY, TIMING_HEIGHTBEFOREOVERLAY};

  assign running   = (state_q != ST_IDLE);
  assign frame_end = running && h_last && v_last;
  assign load      = start_acc || frame_end;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    started_d = 1'b0;
    stopped_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START && !STOP && (h_lens != '0) && (v_lens != '0)) begin
          state_d   = ST_RUNNING;
          start_acc = 1'b1;
          started_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (STOP) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (frame_end) begin
          state_d   = ST_IDLE;
          stopped_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      STARTED <= 1'b0;
      STOPPED <= 1'b0;
    end else begin
      state_q <= state_d;
      STARTED <= started_d;
      STOPPED <= stopped_d;
    end
  end

  assign STATE = state_q;

  dso100fb_timing_axis u_haxis (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (load),
    .ADVANCE  (running),
    .LEN_IN   (h_lens),
    .SEG      (h_seg),
    .AT_FIRST (h_first),
    .LAST     (h_last)
  );

  dso100fb_timing_axis u_vaxis (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (load),
    .ADVANCE  (running && h_last),
    .LEN_IN   (v_lens),
    .SEG      (v_seg),
    .AT_FIRST (v_first),
    .LAST     (v_last)
  );

  always_comb begin
    de_act = running && (h_seg <= SEG_AFTER) && (v_seg <= SEG_AFTER);
    hs_act = running && (h_seg == SEG_SYNC);
    vs_act = running && (v_seg == SEG_SYNC);
`ifdef DSO100FB_TIMING_OVERLAY_EN
    ovl_act = running && (h_seg == SEG_OVERLAY) && (v_seg == SEG_OVERLAY);
`else
    ovl_act = 1'b0;
`endif
  end

  // Qualifiers lag the counters by one cycle; polarity is applied at the register input.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HSYNC       <= 1'b0;
      VSYNC       <= 1'b0;
      DE          <= 1'b0;
      OVERLAY     <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      HSYNC       <= hs_act ~^ HSYNC_POLARITY;
      VSYNC       <= vs_act ~^ VSYNC_POLARITY;
      DE          <= de_act ~^ DE_POLARITY;
      OVERLAY     <= ovl_act;
      LINE_START  <= running && h_first;
      FRAME_START <= running && h_first && v_first;
    end
  end

endmodule

// File: tb/tb_dso100fb_timing.sv
// Directed self-checking bench for dso100fb_timing.
module tb_dso100fb_timing;

  logic        CLK, RST, START, STOP;
  logic        STARTED, STOPPED;
  logic [1:0]  STATE;
  logic [11:0] TIMING_WIDTHBEFOREOVERLAY, TIMING_WIDTHOVERLAY, TIMING_WIDTHAFTEROVERLAY;
  logic [11:0] TIMING_HFRONTPORCH, TIMING_HSYNCPULSE, TIMING_HBACKPORCH;
  logic [11:0] TIMING_HEIGHTBEFOREOVERLAY, TIMING_HEIGHTOVERLAY, TIMING_HEIGHTAFTEROVERLAY;
  logic [11:0] TIMING_VFRONTPORCH, TIMING_VSYNCPULSE, TIMING_VBACKPORCH;
  logic        HSYNC_POLARITY, VSYNC_POLARITY, DE_POLARITY;
  logic        HSYNC, VSYNC, DE, OVERLAY, LINE_START, FRAME_START;

  int vectors = 0;
  int miscompares = 0;
  int hl[6];
  int vl[6];

  dso100fb_timing dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .STARTED(STARTED), .STOPPED(STOPPED), .STATE(STATE),
    .TIMING_WIDTHBEFOREOVERLAY(TIMING_WIDTHBEFOREOVERLAY),
    .TIMING_WIDTHOVERLAY(TIMING_WIDTHOVERLAY),
    .TIMING_WIDTHAFTEROVERLAY(TIMING_WIDTHAFTEROVERLAY),
    .TIMING_HFRONTPORCH(TIMING_HFRONTPORCH),
    .TIMING_HSYNCPULSE(TIMING_HSYNCPULSE),
    .TIMING_HBACKPORCH(TIMING_HBACKPORCH),
    .TIMING_HEIGHTBEFOREOVERLAY(TIMING_HEIGHTBEFOREOVERLAY),
    .TIMING_HEIGHTOVERLAY(TIMING_HEIGHTOVERLAY),
    .TIMING_HEIGHTAFTEROVERLAY(TIMING_HEIGHTAFTEROVERLAY),
    .TIMING_VFRONTPORCH(TIMING_VFRONTPORCH),
    .TIMING_VSYNCPULSE(TIMING_VSYNCPULSE),
    .TIMING_VBACKPORCH(TIMING_VBACKPORCH),
    .HSYNC_POLARITY(HSYNC_POLARITY), .VSYNC_POLARITY(VSYNC_POLARITY), .DE_POLARITY(DE_POLARITY),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .OVERLAY(OVERLAY),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] observed();
    return {6'd0, STATE, STARTED, STOPPED, HSYNC, VSYNC, DE, OVERLAY, LINE_START, FRAME_START};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_timing();
    TIMING_WIDTHBEFOREOVERLAY  = 12'(hl[0]);
    TIMING_WIDTHOVERLAY        = 12'(hl[1]);
    TIMING_WIDTHAFTEROVERLAY   = 12'(hl[2]);
    TIMING_HFRONTPORCH         = 12'(hl[3]);
    TIMING_HSYNCPULSE          = 12'(hl[4]);
    TIMING_HBACKPORCH          = 12'(hl[5]);
    TIMING_HEIGHTBEFOREOVERLAY = 12'(vl[0]);
    TIMING_HEIGHTOVERLAY       = 12'(vl[1]);
    TIMING_HEIGHTAFTEROVERLAY  = 12'(vl[2]);
    TIMING_VFRONTPORCH         = 12'(vl[3]);
    TIMING_VSYNCPULSE          = 12'(vl[4]);
    TIMING_VBACKPORCH          = 12'(vl[5]);
  endtask

  function automatic int seg_of(input int pos, input bit vert);
    int acc;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc += vert ? vl[i] : hl[i];
      if (pos < acc) return i;
    end
    return 6;
  endfunction

  // START accepted: STARTED/STATE one cycle later, first pixel qualifiers the cycle after.
  task automatic do_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("started", 16'(observed() >> 7), 16'b011);
    @(negedge CLK);
  endtask

  // Check ncyc output cycles against the timing model; optional STOP after cycle stop_k.
  task automatic run(input int ncyc, input int stop_k);
    int hsum, vsum, fl, k_end, p, hpos, line, hs_i, vs_i;
    logic act, de, hs, vs, ov, ls, fs, stp;
    logic [1:0] st;
    hsum = 0;
    vsum = 0;
    for (int i = 0; i < 6; i++) begin
      hsum += hl[i];
      vsum += vl[i];
    end
    fl = hsum * vsum;
    k_end = (stop_k >= 0) ? ((stop_k / fl + 1) * fl - 1) : ncyc + 1;
    for (int k = 0; k < ncyc; k++) begin
      STOP = 1'b0;
      p    = k % fl;
      hpos = p % hsum;
      line = p / hsum;
      hs_i = seg_of(hpos, 1'b0);
      vs_i = seg_of(line, 1'b1);
      act  = (k <= k_end);
      de   = act && hs_i <= 2 && vs_i <= 2;
      hs   = act && hs_i == 4;
      vs   = act && vs_i == 4;
`ifdef DSO100FB_TIMING_OVERLAY_EN
      ov   = act && hs_i == 1 && vs_i == 1;
`else
      ov   = 1'b0;
`endif
      ls   = act && hpos == 0;
      fs   = act && p == 0;
      st   = (stop_k < 0 || k <= stop_k) ? 2'b01 : ((k < k_end) ? 2'b10 : 2'b00);
      stp  = (k == k_end);
      chk($sformatf("cycle%0d", k), observed(),
          {6'd0, st, 1'b0, stp, hs ~^ HSYNC_POLARITY, vs ~^ VSYNC_POLARITY,
           de ~^ DE_POLARITY, ov, ls, fs});
      if (k == stop_k) STOP = 1'b1;
      @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    STOP = 1'b0;
    HSYNC_POLARITY = 1'b1;
    VSYNC_POLARITY = 1'b1;
    DE_POLARITY = 1'b1;
    hl = '{2, 2, 2, 1, 1, 1};
    vl = '{1, 1, 1, 1, 1, 1};
    apply_timing();
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_state", observed(), 16'h0000);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_pins_pol1", observed(), 16'h0000);

    // Two full frames then STOP ten cycles into the third.
    do_start();
    run(170, 118);

    // Active-low pins: idle high, resets to 0.
    HSYNC_POLARITY = 1'b0;
    VSYNC_POLARITY = 1'b0;
    DE_POLARITY = 1'b0;
    @(negedge CLK);
    chk("idle_pins_pol0", observed(), 16'h0038);
    RST = 1'b1;
    #1;
    chk("reset_pol0", observed(), 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("release_pol0", observed(), 16'h0038);
    do_start();
    run(60, 10);

    // Zero-length sync pulse is skipped: 5-cycle lines.
    HSYNC_POLARITY = 1'b1;
    VSYNC_POLARITY = 1'b1;
    DE_POLARITY = 1'b1;
    hl = '{1, 1, 1, 1, 0, 1};
    apply_timing();
    @(negedge CLK);
    do_start();
    run(35, 3);

    // All horizontal lengths zero: START rejected.
    hl = '{0, 0, 0, 0, 0, 0};
    apply_timing();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("reject_start", observed(), 16'h0000);
    @(negedge CLK);
    chk("reject_idle", observed(), 16'h0000);

    // START and STOP together in IDLE: STOP wins.
    hl = '{2, 2, 2, 1, 1, 1};
    apply_timing();
    START = 1'b1;
    STOP = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    STOP = 1'b0;
    chk("start_stop_idle", observed(), 16'h0000);

    // Asynchronous reset mid-line, then a clean restart at line 0.
    do_start();
    run(13, -1);
    RST = 1'b1;
    #1;
    chk("reset_midline", observed(), 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("after_reset", observed(), 16'h0000);
    do_start();
    run(60, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
